rr_mux_arbiter_4x1: RTL

//   Shares one 4x1 data multiplexer between four requesters.
//   - Arbitrates round-robin over req[3:0] and drives the mux select.
//   - Presents the granted source on a valid/ready output port.
//   - Caps how many transfers one grant holder may make while others wait.
//   - Sits between the four source channels and the single downstream consumer.

---
 rtl/rr_mux_arbiter_4x1_pkg.sv | 18 +
 rtl/rr_mux_arbiter_4x1_if.sv | 33 +++
 rtl/rr_mux_arbiter_4x1_pick.sv | 39 +++
 rtl/rr_mux_arbiter_4x1.sv | 121 ++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_4x1_pkg.sv
// Shared constants and helpers for the 4-requester mux arbiter.
// Latency: none (definitions only).
// Backpressure: n/a.
package rr_mux_arbiter_4x1_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    // FSM encodings kept as plain constants for compatibility with older flows
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Convert a requester index into its one-hot grant vector
    function automatic logic [NUM_REQ-1:0] sel2onehot(input logic [SEL_W-1:0] s);
        return NUM_REQ'(1) << s;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_4x1_if.sv
// Bundle of request/data inputs and grant/valid-ready output of the mux arbiter.
// Latency: none (wiring only).
// Backpressure: out_ready travels master -> slave alongside the requests.
//   master : requesters + downstream consumer (drives req, din0..3, out_ready)
//   slave  : arbiter (drives gnt, sel, out_valid, dout)
interface rr_mux_arbiter_4x1_if
    import rr_mux_arbiter_4x1_pkg::*;
#(
    parameter int DATA_W = 8
) ();

    logic [NUM_REQ-1:0] req;
    logic [DATA_W-1:0]  din0;
    logic [DATA_W-1:0]  din1;
    logic [DATA_W-1:0]  din2;
    logic [DATA_W-1:0]  din3;
    logic               out_ready;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               out_valid;
    logic [DATA_W-1:0]  dout;

    modport master (
        output req, din0, din1, din2, din3, out_ready,
        input  gnt, sel, out_valid, dout
    );

    modport slave (
        input  req, din0, din1, din2, din3, out_ready,
        output gnt, sel, out_valid, dout
    );

endinterface

// File: rtl/rr_mux_arbiter_4x1_pick.sv
// Rotating first-set picker: finds the first unmasked req starting at ptr.
// Latency: combinational.
// Backpressure: none.
//   req  : request vector       ptr : search start index
//   mask : bits excluded         any : a winner exists      idx : winner index
module rr_pick4
    import rr_mux_arbiter_4x1_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0]   w_elig;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]     w_off;

    // Rotate so that bit 0 of w_rot corresponds to requester ptr
    assign w_elig = req & ~mask;
    assign w_dbl  = {w_elig, w_elig} >> ptr;
    assign w_rot  = w_dbl[NUM_REQ-1:0];

    always_comb begin
        w_off = '0;
        // Scan downwards so the lowest rotated position wins
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SEL_W'(k);
            end
        end
    end

    assign any = |w_rot;
    assign idx = ptr + w_off;

endmodule

// File: rtl/rr_mux_arbiter_4x1.sv
// Round-robin arbiter sharing one 4:1 data mux, with a per-grant transfer cap.
// Latency: 1 cycle req->gnt from idle; back-to-back grants with no bubble.
// Backpressure: out_ready gates transfers; the hold count only advances on accepted beats.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : req[3:0], din0..3, out_ready in; gnt, sel, out_valid, dout out
//   Define ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module rr_mux_arbiter_4x1
    import rr_mux_arbiter_4x1_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_mux_arbiter_4x1_if.slave  bus
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [0:0]          r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_ptr;
    logic [HOLD_W-1:0]   r_hold_cnt;

    logic                w_active;
    logic                w_own_req;
    logic                w_out_valid;
    logic                w_xfer;
    logic                w_hold_last;
    logic                w_rival;
    logic                w_release;
    logic [SEL_W-1:0]    w_pick_ptr;
    logic                w_pick_any;
    logic [SEL_W-1:0]    w_pick_idx;
    logic [DATA_W-1:0]   w_din_sel;

    assign w_active    = (r_state == ST_GRANT);
    assign w_own_req   = bus.req[r_sel];
    assign w_out_valid = w_active & w_own_req;
    assign w_xfer      = w_out_valid & bus.out_ready;
    assign w_hold_last = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));

`ifdef ARB_FIXED_PRIO_EN
    // Only a lower-index requester may force the holder off; ptr stays at 0
    assign w_rival    = |(bus.req & (sel2onehot(r_sel) - NUM_REQ'(1)));
    assign w_pick_ptr = r_ptr;
`else
    logic [SEL_W-1:0] w_sel_nxt;
    assign w_sel_nxt  = r_sel + SEL_W'(1);
    assign w_rival    = |(bus.req & ~sel2onehot(r_sel));
    // Idle picks resume from ptr; a releasing holder hands off starting after itself
    assign w_pick_ptr = w_active ? w_sel_nxt : r_ptr;
`endif

    assign w_release = w_active & (~w_own_req | (w_xfer & w_hold_last & w_rival));

    // r_gnt is zero when idle and the holder's bit when granted, so it doubles
    // as the "exclude the releasing requester" mask for back-to-back picks
    rr_pick4 u_pick (
        .req  (bus.req),
        .ptr  (w_pick_ptr),
        .mask (r_gnt),
        .any  (w_pick_any),
        .idx  (w_pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_sel      <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_state    <= ST_GRANT;
                        r_gnt      <= sel2onehot(w_pick_idx);
                        r_sel      <= w_pick_idx;
                        r_hold_cnt <= '0;
                    end
                end
                default: begin
                    if (w_release) begin
                        r_hold_cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
                        r_ptr      <= w_sel_nxt;
`endif
                        if (w_pick_any) begin
                            r_gnt <= sel2onehot(w_pick_idx);
                            r_sel <= w_pick_idx;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= '0;
                        end
                    end else if (w_xfer) begin
                        // With nobody waiting the cap does not bite; restart the count
                        r_hold_cnt <= w_hold_last ? '0 : r_hold_cnt + HOLD_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        case (r_sel)
            2'd0:    w_din_sel = bus.din0;
            2'd1:    w_din_sel = bus.din1;
            2'd2:    w_din_sel = bus.din2;
            default: w_din_sel = bus.din3;
        endcase
    end

    assign bus.gnt       = r_gnt;
    assign bus.sel       = r_sel;
    assign bus.out_valid = w_out_valid;
    assign bus.dout      = w_out_valid ? w_din_sel : '0;

endmodule
